mem_fill_responder: RTL and testbench

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

---
 rtl/mem_fill_responder.sv | 159 +++++++++++++++
 tb/tb_mem_fill_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// -----------------------------------------------------------------------------
// mem_fill_responder
//
// Word-addressed 16-bit memory that answers reads through a fixed-latency
// pipeline. Every cycle with enable=1 is accepted as one request: a write
// updates the addressed word at that edge, and a read captures the word at
// that edge and returns it LATENCY cycles later as a one-cycle data_valid
// pulse. Back-to-back reads return back-to-back, in order.
//
// Parameters
//   LATENCY    cycles from read request to data_valid (1..8)
//   ADDR_BITS  word-index width; storage is 2**ADDR_BITS x 16 bits
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (storage is preserved)
//   enable       request strobe, one request per cycle
//   wr           1 = write, 0 = read (when enable=1)
//   addr         byte address; word index = addr[ADDR_BITS:1]
//   data_in      write data
//   data_out     read data, 16'h0000 whenever data_valid=0
//   data_valid   one-cycle pulse per accepted read
//   outstanding  accepted reads not yet returned (0..LATENCY)
// -----------------------------------------------------------------------------
module mem_fill_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  outstanding
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // Storage starts at zero and is deliberately untouched by reset.
    logic [15:0] mem_q [DEPTH] = '{default: 16'h0000};

    logic [ADDR_BITS-1:0] word_idx;
    logic                 accept_rd;
    logic                 accept_wr;

    // Requests seen while rst is high are dropped entirely.
    assign word_idx  = addr[ADDR_BITS:1];
    assign accept_rd = enable & ~wr & ~rst;
    assign accept_wr = enable &  wr & ~rst;

    // addr[0] and the bits above the word index only alias; they carry no
    // meaning inside the block.
    logic unused_addr_lo;
    assign unused_addr_lo = addr[0];

    if (ADDR_BITS < 15) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[15:ADDR_BITS+1];
    end

    // -------------------------------------------------------------------------
    // Storage with registered read. The read register doubles as pipeline
    // stage 0; it loads zero on any cycle that is not an accepted read so that
    // empty pipeline slots always carry 16'h0000 and data_out needs no mask.
    // -------------------------------------------------------------------------
    logic [15:0] rd_word_q;

    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem_q[word_idx] <= data_in;
        end
        if (accept_rd) begin
            rd_word_q <= mem_q[word_idx];
        end else begin
            rd_word_q <= 16'h0000;
        end
    end

    // -------------------------------------------------------------------------
    // Valid pipeline: bit 0 is loaded at the acceptance edge, bit LATENCY-1
    // is data_valid.
    // -------------------------------------------------------------------------
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;

    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = accept_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Data pipeline: stage_data[0] is the read register, each further stage
    // is a plain shift register. The data captured at acceptance travels
    // alone, so later writes to the same word cannot disturb it.
    // -------------------------------------------------------------------------
    logic [15:0] stage_data [LATENCY];

    assign stage_data[0] = rd_word_q;

    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
        logic [15:0] data_q;
        logic [15:0] data_d;

        always_comb begin
            data_d = stage_data[gi-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= 16'h0000;
            end else begin
                data_q <= data_d;
            end
        end

        assign stage_data[gi] = data_q;
    end

    // -------------------------------------------------------------------------
    // Outstanding counter: +1 on acceptance, -1 on return, unchanged when both
    // happen together. It mirrors the number of set valid bits, so it is
    // bounded by LATENCY by construction.
    // -------------------------------------------------------------------------
    logic [3:0] outstanding_q;
    logic [3:0] outstanding_d;

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept_rd && !valid_q[LATENCY-1]) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept_rd && valid_q[LATENCY-1]) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= 4'd0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign data_valid  = valid_q[LATENCY-1];
    assign data_out    = stage_data[LATENCY-1];
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_responder
//
// Directed scenarios with spec-derived expected values, followed by a long
// randomized run checked cycle by cycle against a reference model made of a
// word array plus a per-cycle history of accepted reads.
// -----------------------------------------------------------------------------
module tb_mem_fill_responder;

    localparam int LAT   = 4;
    localparam int AB    = 8;
    localparam int DEPTH = 256;
    localparam int HIST  = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  outstanding;

    always #5 clk = ~clk;

    mem_fill_responder #(
        .LATENCY   (LAT),
        .ADDR_BITS (AB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr          (wr),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .outstanding (outstanding)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: memory contents, and which cycles issued an accepted
    // read together with the word it saw.
    logic [15:0] model_mem    [DEPTH];
    bit          rd_hist      [HIST];
    logic [15:0] rd_data_hist [HIST];

    // Observed and model-expected outputs for the cycle just sampled.
    logic        obs_dv;
    logic [15:0] obs_do;
    logic [3:0]  obs_out;
    logic        exp_dv;
    logic [15:0] exp_do;
    logic [3:0]  exp_out;

    function automatic int widx(input logic [15:0] a);
        return int'(a[AB:1]);
    endfunction

    // One cycle: sample outputs of cycle 'cyc' at the falling edge, compute
    // the model's expectation for that cycle, then present this cycle's
    // request and fold it into the model.
    task automatic step(input logic r, input logic en, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        int cnt;
        @(negedge clk);
        if (cyc >= HIST - 1) begin
            $display("FAIL cycle_budget cyc=%0d exceeds %0d", cyc, HIST - 1);
            $fatal(1, "cycle budget exhausted");
        end
        obs_dv  = data_valid;
        obs_do  = data_out;
        obs_out = outstanding;
        exp_dv  = (cyc >= LAT) ? rd_hist[cyc-LAT] : 1'b0;
        exp_do  = exp_dv ? rd_data_hist[cyc-LAT] : 16'h0000;
        cnt = 0;
        for (int j = cyc - LAT; j < cyc; j++) begin
            if (j >= 0 && rd_hist[j]) cnt++;
        end
        exp_out = 4'(cnt);
        $display("cyc=%0d rst=%0b en=%0b wr=%0b addr=%h din=%h | dv=%0b dout=%h outst=%0d",
                 cyc, r, en, w, a, d, obs_dv, obs_do, obs_out);
        rst     = r;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        rd_hist[cyc]      = 1'b0;
        rd_data_hist[cyc] = 16'h0000;
        if (r) begin
            for (int j = cyc - LAT; j < cyc; j++) begin
                if (j >= 0) rd_hist[j] = 1'b0;
            end
        end else if (en && w) begin
            model_mem[widx(a)] = d;
        end else if (en) begin
            rd_hist[cyc]      = 1'b1;
            rd_data_hist[cyc] = model_mem[widx(a)];
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eo;
        // Requests while in reset must be ignored; outputs stay cleared.
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      step(1'b1, 1'b1, 1'b1, 16'h0002, 16'hDEAD);
            else if (k == 1) step(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
            else             step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {1'b0, 16'h0000, 4'd0}) begin
                $display("FAIL reset_state k=%0d got dv=%0b dout=%h outst=%0d want 0/0000/0",
                         k, obs_dv, obs_do, obs_out);
            end else n_pass++;
        end
        // The write during reset never happened, so the word still reads 0.
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) step(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000);
            else        idle();
            ev = (k == 4);
            ed = 16'h0000;
            eo = (k >= 1 && k <= 4) ? 4'd1 : 4'd0;
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {ev, ed, eo}) begin
                $display("FAIL reset_ignore k=%0d got dv=%0b dout=%h outst=%0d want dv=%0b dout=%h outst=%0d",
                         k, obs_dv, obs_do, obs_out, ev, ed, eo);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_read();
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eo;
        step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        idle();
        for (int k = 0; k <= 6; k++) begin
            if (k == 0) step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
            else        idle();
            ev = (k == 4);
            ed = ev ? 16'hBEEF : 16'h0000;
            eo = (k >= 1 && k <= 4) ? 4'd1 : 4'd0;
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {ev, ed, eo}) begin
                $display("FAIL single_read k=%0d got dv=%0b dout=%h outst=%0d want dv=%0b dout=%h outst=%0d",
                         k, obs_dv, obs_do, obs_out, ev, ed, eo);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fill_burst();
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eo;
        int          lo, hi, peak;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h1230 + 16'(2 * i), 16'h1000 + 16'(i));
        end
        peak = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 8) step(1'b0, 1'b1, 1'b0, 16'h1230 + 16'(2 * k), 16'h0000);
            else       idle();
            ev = (k >= 4 && k < 12);
            ed = ev ? 16'h1000 + 16'(k - 4) : 16'h0000;
            lo = (k - 4 > 0) ? k - 4 : 0;
            hi = (k - 1 < 7) ? k - 1 : 7;
            eo = (hi >= lo) ? 4'(hi - lo + 1) : 4'd0;
            if (int'(obs_out) > peak) peak = int'(obs_out);
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {ev, ed, eo}) begin
                $display("FAIL fill_burst k=%0d got dv=%0b dout=%h outst=%0d want dv=%0b dout=%h outst=%0d",
                         k, obs_dv, obs_do, obs_out, ev, ed, eo);
            end else n_pass++;
        end
        n_checks++;
        if (peak != 4) begin
            $display("FAIL fill_peak got %0d want 4", peak);
        end else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_overwrite();
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eo;
        step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h00AA);
        idle();
        for (int k = 0; k <= 9; k++) begin
            case (k)
                0:       step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
                1:       step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
                4:       step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
                default: idle();
            endcase
            ev = (k == 4 || k == 8);
            ed = (k == 4) ? 16'h00AA : ((k == 8) ? 16'h5555 : 16'h0000);
            eo = (k >= 1 && k <= 8) ? 4'd1 : 4'd0;
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {ev, ed, eo}) begin
                $display("FAIL overwrite k=%0d got dv=%0b dout=%h outst=%0d want dv=%0b dout=%h outst=%0d",
                         k, obs_dv, obs_do, obs_out, ev, ed, eo);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_alias();
        logic        ev;
        logic [15:0] ed;
        for (int k = 0; k <= 6; k++) begin
            case (k)
                0:       step(1'b0, 1'b1, 1'b1, 16'h0041, 16'hCAFE);
                1:       step(1'b0, 1'b1, 1'b0, 16'hFE40, 16'h0000);
                default: idle();
            endcase
            ev = (k == 5);
            ed = ev ? 16'hCAFE : 16'h0000;
            n_checks++;
            if ({obs_dv, obs_do} !== {ev, ed}) begin
                $display("FAIL alias k=%0d got dv=%0b dout=%h want dv=%0b dout=%h",
                         k, obs_dv, obs_do, ev, ed);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  eo;
        for (int k = 0; k <= 15; k++) begin
            if (k < 3)       step(1'b0, 1'b1, 1'b0, 16'h1230 + 16'(2 * k), 16'h0000);
            else if (k == 3) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            else if (k == 10) step(1'b0, 1'b1, 1'b0, 16'h1232, 16'h0000);
            else             idle();
            // Up to the reset edge outstanding climbs 0,1,2,3; afterwards the
            // only pulse is the post-reset read returning the stored 16'h1001.
            ev = (k == 14);
            ed = ev ? 16'h1001 : 16'h0000;
            eo = (k <= 3) ? 4'(k) : ((k >= 11 && k <= 14) ? 4'd1 : 4'd0);
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {ev, ed, eo}) begin
                $display("FAIL reset_mid_burst k=%0d got dv=%0b dout=%h outst=%0d want dv=%0b dout=%h outst=%0d",
                         k, obs_dv, obs_do, obs_out, ev, ed, eo);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_bubbles();
        logic        ev;
        logic [15:0] ed;
        for (int k = 0; k <= 8; k++) begin
            case (k)
                0:       step(1'b0, 1'b1, 1'b0, 16'h1230, 16'h0000);
                2:       step(1'b0, 1'b1, 1'b1, 16'h0060, 16'h7777);
                3:       step(1'b0, 1'b1, 1'b0, 16'h1238, 16'h0000);
                default: idle();
            endcase
            ev = (k == 4 || k == 7);
            ed = (k == 4) ? 16'h1000 : ((k == 7) ? 16'h1004 : 16'h0000);
            n_checks++;
            if ({obs_dv, obs_do} !== {ev, ed}) begin
                $display("FAIL bubbles k=%0d got dv=%0b dout=%h want dv=%0b dout=%h",
                         k, obs_dv, obs_do, ev, ed);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_random();
        logic        r, en, w;
        logic [15:0] a, d;
        for (int i = 0; i < 1500 + LAT + 2; i++) begin
            if (i < 1500) begin
                r  = ($urandom_range(0, 63) == 0);
                en = ($urandom_range(0, 3) != 0);
                w  = 1'($urandom_range(0, 1));
                a  = 16'($urandom);
                a[8:5] = 4'h0;   // 16 words, many aliases: frequent hits
                d  = 16'($urandom);
                step(r, en, w, a, d);
            end else begin
                step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            n_checks++;
            if ({obs_dv, obs_do, obs_out} !== {exp_dv, exp_do, exp_out}) begin
                $display("FAIL random cyc=%0d got dv=%0b dout=%h outst=%0d want dv=%0b dout=%h outst=%0d",
                         cyc - 1, obs_dv, obs_do, obs_out, exp_dv, exp_do, exp_out);
            end else n_pass++;
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;

        test_reset();
        test_single_read();
        test_fill_burst();
        test_overwrite();
        test_alias();
        test_reset_mid_burst();
        test_bubbles();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
